regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the decode stage. It is the successor of the single-write, two-read file.
- Adds configurable read and write port counts, synchronous-write / combinational-read with optional write-to-read bypass, and asynchronous clear.
- Adds a per-register busy scoreboard: decode sets a register's bit at issue, writeback clears it, which lets the hazard unit stall on pending destinations.
- Register 0 is hardwired to zero and is never busy.

Parameters:
- DATA_WIDTH, 32, width of each register.
- NUM_REGS, 32, number of architectural registers including x0 (2..32).
- ADDR_WIDTH, 5, register index width; must satisfy 2**ADDR_WIDTH >= NUM_REGS.
- RD_PORTS, 2, number of read ports.
- WR_PORTS, 2, number of write ports.
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads; 0 = reads see the stored value only.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- raddr  in  RD_PORTS*ADDR_WIDTH  packed read indices; port i = bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  out  RD_PORTS*DATA_WIDTH  packed read data, combinational.
- rbusy  out  RD_PORTS  busy bit of the register addressed by each read port, combinational.
- we  in  WR_PORTS  write enable per write port.
- waddr  in  WR_PORTS*ADDR_WIDTH  packed write indices.
- wdata  in  WR_PORTS*DATA_WIDTH  packed write data.
- alloc_valid  in  1  issue of an instruction with a destination register.
- alloc_rd  in  ADDR_WIDTH  destination index to mark busy.
- busy_vec  out  NUM_REGS  full scoreboard; bit 0 is always 0.

Behaviour:
- Reset: the clock and reset are decided as one clock clk, with reset rst_n asynchronous and active-low.
  - While rst_n=0, all registers are 0 and all busy bits are 0.
  - Outputs during reset: rdata=0, rbusy=0, busy_vec=0.
  - Writes and allocs are ignored during reset and bypass is disabled.
  - Release of rst_n is synchronised externally; the first update happens on the first rising clk after release.
- Write: on a rising clk, for each port j with we[j]=1, waddr[j]!=0 and waddr[j]<NUM_REGS, mem[waddr[j]] <= wdata[j]. Latency is 1 cycle to storage.
- Write conflict: if two ports write the same index in one cycle, the highest-numbered port wins.
- Read: rdata[i] is combinational from raddr[i].
  - raddr=0 or raddr>=NUM_REGS returns 0.
  - With BYPASS=1, when a live write targets raddr[i] in the same cycle, rdata[i] is that write's wdata, using the highest matching port. There is no bypass for index 0.
  - With BYPASS=0, rdata[i] returns the stored value only; the new value is visible the cycle after the write.
- Scoreboard, evaluated at the rising clk:
  - A valid write to reg r clears busy[r].
  - alloc_valid with alloc_rd=r (r!=0, r<NUM_REGS) sets busy[r].
  - A same-cycle alloc and write to the same r leaves busy[r]=1: alloc wins, because the write completes the older instruction.
  - Allocs to 0 or to an out-of-range index are ignored.
  - Allocating an already-busy register keeps it at 1.
  - A write to a register that is not busy leaves it at 0.
- rbusy[i] = busy[raddr[i]] from current state, with no bypass of same-cycle clears. The hazard unit therefore sees the clear one cycle later, which is conservative and correct.
- Reset mid-operation: asserting rst_n asynchronously clears the stored data and the scoreboard immediately; in-flight writes in that cycle are lost.
- X handling: waddr and wdata are don't-care when we[j]=0, and alloc_rd is don't-care when alloc_valid=0. Neither may affect any state.

Decomposition:
- The shared decode package holds:
  - REG_ZERO = 0.
  - Default XLEN = 32.
  - NUM_ARCH_REGS = 32.
  - The reg-index typedef of ADDR_WIDTH bits.
- One natural sub-module is regfile_scoreboard: the busy vector with set/clear arbitration, taking the write-port enables/addresses and the alloc inputs.
- The data array, write-port priority and bypass mux stay in regfile_mp.

Test Plan:
- Reset clear: hold rst_n=0, then read every index on both ports -> rdata=0, busy_vec=0. Write x5=0xDEADBEEF, assert rst_n=0 mid-cycle -> x5 reads 0 immediately.
- x0 immunity: we[0]=1, waddr=0, wdata=0xFFFFFFFF, and alloc_rd=0 -> raddr=0 returns 0 and busy_vec[0]=0.
- Write conflict: port0 writes x3=0x11111111 and port1 writes x3=0x22222222 in the same cycle -> next cycle x3=0x22222222.
  - With BYPASS=1, the same-cycle read of x3 returns 0x22222222.
- Bypass mode: BYPASS=1, write x7=0x1234 while reading x7 -> rdata=0x1234 in the same cycle. With BYPASS=0 the same read returns the old value 0, then 0x1234 the next cycle.
- Scoreboard: alloc x9 -> busy[9]=1 next cycle. Write x9 -> busy[9]=0 next cycle. Alloc x9 and write x9 in the same cycle -> busy[9] stays 1.
- Out of range, with NUM_REGS=16 and ADDR_WIDTH=5: write x20 and alloc x20 -> no state change; raddr=20 returns 0 and rbusy=0.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared decode-stage definitions: architectural defaults and the register index type.
package regfile_mp_pkg;

  localparam int XLEN          = 32;
  localparam int NUM_ARCH_REGS = 32;
  localparam int REG_IDX_W     = 5;
  localparam int REG_ZERO      = 0;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: alloc sets, writeback clears, alloc wins on a same-cycle collision.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int NUM_REGS   = NUM_ARCH_REGS,
  parameter int ADDR_WIDTH = REG_IDX_W,
  parameter int WR_PORTS   = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [WR_PORTS-1:0]            we,
  input  logic [WR_PORTS*ADDR_WIDTH-1:0] waddr,
  input  logic                           alloc_valid,
  input  logic [ADDR_WIDTH-1:0]          alloc_rd,
  output logic [NUM_REGS-1:0]            busy_vec
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  // Decoding against each legal index leaves x0 and out-of-range indices with no set/clear at all.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int r = REG_ZERO + 1; r < NUM_REGS; r++) begin
      set_vec[r] = alloc_valid && (alloc_rd == ADDR_WIDTH'(r));
      for (int j = 0; j < WR_PORTS; j++) begin
        if (we[j] && (waddr[j*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r))) begin
          clr_vec[r] = 1'b1;
        end
      end
    end
    busy_d = set_vec | (busy_q & ~clr_vec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional same-cycle write bypass and a busy scoreboard.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int NUM_REGS   = NUM_ARCH_REGS,
  parameter int ADDR_WIDTH = $bits(reg_idx_t),
  parameter int RD_PORTS   = 2,
  parameter int WR_PORTS   = 2,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [RD_PORTS*ADDR_WIDTH-1:0] raddr,
  output logic [RD_PORTS*DATA_WIDTH-1:0] rdata,
  output logic [RD_PORTS-1:0]            rbusy,
  input  logic [WR_PORTS-1:0]            we,
  input  logic [WR_PORTS*ADDR_WIDTH-1:0] waddr,
  input  logic [WR_PORTS*DATA_WIDTH-1:0] wdata,
  input  logic                           alloc_valid,
  input  logic [ADDR_WIDTH-1:0]          alloc_rd,
  output logic [NUM_REGS-1:0]            busy_vec
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];

  // Ports are visited in ascending order so the highest-numbered matching port wins.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      mem_d[r] = mem_q[r];
    end
    mem_d[REG_ZERO] = '0;
    for (int j = 0; j < WR_PORTS; j++) begin
      for (int r = REG_ZERO + 1; r < NUM_REGS; r++) begin
        if (we[j] && (waddr[j*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r))) begin
          mem_d[r] = wdata[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        mem_q[r] <= mem_d[r];
      end
    end
  end

  regfile_scoreboard #(
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .WR_PORTS   (WR_PORTS)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .we          (we),
    .waddr       (waddr),
    .alloc_valid (alloc_valid),
    .alloc_rd    (alloc_rd),
    .busy_vec    (busy_vec)
  );

  genvar gi;
  for (gi = 0; gi < RD_PORTS; gi++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;
    logic                  rb;
    logic                  hit;

    assign ra = raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];

    // hit is set only for a legal nonzero index, which also keeps x0 out of the bypass path.
    always_comb begin
      rd  = '0;
      rb  = 1'b0;
      hit = 1'b0;
      for (int r = REG_ZERO + 1; r < NUM_REGS; r++) begin
        if (ra == ADDR_WIDTH'(r)) begin
          rd  = mem_q[r];
          rb  = busy_vec[r];
          hit = 1'b1;
        end
      end
      if (BYPASS && rst_n && hit) begin
        for (int j = 0; j < WR_PORTS; j++) begin
          if (we[j] && (waddr[j*ADDR_WIDTH +: ADDR_WIDTH] == ra)) begin
            rd = wdata[j*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end

    assign rdata[gi*DATA_WIDTH +: DATA_WIDTH] = rd;
    assign rbusy[gi]                          = rb;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default, non-bypass and 16-register instances share one stimulus.
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic [9:0]  raddr;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;

  logic [63:0] rdata_a, rdata_n, rdata_s;
  logic [1:0]  rbusy_a, rbusy_n, rbusy_s;
  logic [31:0] busy_a, busy_n;
  logic [15:0] busy_s;

  int errors = 0;
  int checks = 0;

  regfile_mp dut_a (
    .clk (clk), .rst_n (rst_n), .raddr (raddr), .rdata (rdata_a), .rbusy (rbusy_a),
    .we (we), .waddr (waddr), .wdata (wdata), .alloc_valid (alloc_valid),
    .alloc_rd (alloc_rd), .busy_vec (busy_a)
  );

  regfile_mp #(.BYPASS(1'b0)) dut_n (
    .clk (clk), .rst_n (rst_n), .raddr (raddr), .rdata (rdata_n), .rbusy (rbusy_n),
    .we (we), .waddr (waddr), .wdata (wdata), .alloc_valid (alloc_valid),
    .alloc_rd (alloc_rd), .busy_vec (busy_n)
  );

  regfile_mp #(.NUM_REGS(16)) dut_s (
    .clk (clk), .rst_n (rst_n), .raddr (raddr), .rdata (rdata_s), .rbusy (rbusy_s),
    .we (we), .waddr (waddr), .wdata (wdata), .alloc_valid (alloc_valid),
    .alloc_rd (alloc_rd), .busy_vec (busy_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 2'b00; waddr = '0; wdata = '0; alloc_valid = 1'b0; alloc_rd = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    raddr = '0;
    idle();
    step();
    step();

    // Reset: every index reads zero on both ports
    for (int idx = 0; idx < 32; idx++) begin
      raddr = {idx[4:0], idx[4:0]};
      #1;
      check("rst_rdata", rdata_a, 64'h0);
    end
    check("rst_busy", {32'h0, busy_a}, 64'h0);

    // Writes/allocs during reset are ignored and bypass is off
    we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'h5555_5555};
    alloc_valid = 1'b1; alloc_rd = 5'd5; raddr = {5'd5, 5'd5};
    #1;
    check("rst_bypass", rdata_a, 64'h0);
    step();
    check("rst_wr_ign", rdata_a, 64'h0);
    check("rst_alloc", {32'h0, busy_a}, 64'h0);
    idle();
    rst_n = 1'b1;
    step();

    // x0 immunity
    we = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'h0, 32'hFFFF_FFFF};
    alloc_valid = 1'b1; alloc_rd = 5'd0; raddr = {5'd0, 5'd0};
    #1;
    check("x0_bypass", rdata_a, 64'h0);
    step();
    idle();
    #1;
    check("x0_rdata", rdata_a, 64'h0);
    check("x0_busy", {32'h0, busy_a}, 64'h0);

    // Write conflict on x3: port 1 wins
    we = 2'b11; waddr = {5'd3, 5'd3}; wdata = {32'h2222_2222, 32'h1111_1111};
    raddr = {5'd0, 5'd3};
    #1;
    check("conf_byp", {32'h0, rdata_a[31:0]}, 64'h2222_2222);
    check("conf_nobyp", {32'h0, rdata_n[31:0]}, 64'h0);
    step();
    idle();
    #1;
    check("conf_a", {32'h0, rdata_a[31:0]}, 64'h2222_2222);
    check("conf_n", {32'h0, rdata_n[31:0]}, 64'h2222_2222);
    check("conf_s", {32'h0, rdata_s[31:0]}, 64'h2222_2222);

    // Bypass of x7 on read port 1
    we = 2'b01; waddr = {5'd0, 5'd7}; wdata = {32'h0, 32'h0000_1234};
    raddr = {5'd7, 5'd3};
    #1;
    check("byp_a", {32'h0, rdata_a[63:32]}, 64'h1234);
    check("byp_n_old", {32'h0, rdata_n[63:32]}, 64'h0);
    step();
    idle();
    #1;
    check("byp_n_new", {32'h0, rdata_n[63:32]}, 64'h1234);

    // Scoreboard: alloc x9 sets busy next cycle
    alloc_valid = 1'b1; alloc_rd = 5'd9; raddr = {5'd0, 5'd9};
    #1;
    check("sb_pre", {62'h0, rbusy_a}, 64'h0);
    step();
    idle();
    #1;
    check("sb_set", {32'h0, busy_a}, 64'h200);
    check("sb_rbusy", {62'h0, rbusy_a}, 64'h1);
    check("sb_set_s", {48'h0, busy_s}, 64'h200);

    // Writeback clears, seen by rbusy only after the edge
    we = 2'b10; waddr = {5'd9, 5'd0}; wdata = {32'h0000_0099, 32'h0};
    #1;
    check("sb_clr_same", {62'h0, rbusy_a}, 64'h1);
    check("sb_wr_byp", {32'h0, rdata_a[31:0]}, 64'h99);
    step();
    idle();
    #1;
    check("sb_clr", {32'h0, busy_a}, 64'h0);

    // Same-cycle alloc and write of x9: alloc wins
    alloc_valid = 1'b1; alloc_rd = 5'd9;
    we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h0000_0A0A};
    step();
    idle();
    #1;
    check("sb_collide", {32'h0, busy_a}, 64'h200);

    // Re-alloc of busy x9 stays set; write to idle x4 stays clear
    alloc_valid = 1'b1; alloc_rd = 5'd9;
    step();
    idle();
    we = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'h0, 32'h0000_0044};
    step();
    idle();
    #1;
    check("sb_realloc", {32'h0, busy_a}, 64'h200);

    // Out of range for the 16-entry instance, legal for the 32-entry one
    we = 2'b01; waddr = {5'd0, 5'd20}; wdata = {32'h0, 32'h0000_ABCD};
    alloc_valid = 1'b1; alloc_rd = 5'd20; raddr = {5'd0, 5'd20};
    #1;
    check("oor_s_byp", {32'h0, rdata_s[31:0]}, 64'h0);
    check("oor_a_byp", {32'h0, rdata_a[31:0]}, 64'hABCD);
    step();
    idle();
    #1;
    check("oor_s_rd", {32'h0, rdata_s[31:0]}, 64'h0);
    check("oor_s_rbusy", {62'h0, rbusy_s}, 64'h0);
    check("oor_s_busy", {48'h0, busy_s}, 64'h200);
    check("oor_a_busy", {32'h0, busy_a}, 64'h0010_0200);
    check("oor_a_rd", {32'h0, rdata_a[31:0]}, 64'hABCD);

    // Top legal index of the 16-entry instance
    alloc_valid = 1'b1; alloc_rd = 5'd15;
    we = 2'b01; waddr = {5'd0, 5'd15}; wdata = {32'h0, 32'h0000_0055};
    raddr = {5'd0, 5'd15};
    step();
    idle();
    #1;
    check("top_s_busy", {48'h0, busy_s}, 64'h8200);
    check("top_s_rd", {32'h0, rdata_s[31:0]}, 64'h55);

    // Asynchronous reset mid-operation
    we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'hDEAD_BEEF};
    raddr = {5'd5, 5'd0};
    step();
    idle();
    #1;
    check("x5_stored", {32'h0, rdata_a[63:32]}, 64'hDEAD_BEEF);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_x5", {32'h0, rdata_a[63:32]}, 64'h0);
    check("arst_busy", {32'h0, busy_a}, 64'h0);
    check("arst_busy_s", {48'h0, busy_s}, 64'h0);

    // In-flight write and alloc while reset is held are lost
    we = 2'b01; waddr = {5'd0, 5'd6}; wdata = {32'h0, 32'h0000_0066};
    alloc_valid = 1'b1; alloc_rd = 5'd6; raddr = {5'd5, 5'd6};
    #1;
    check("arst_byp", rdata_a, 64'h0);
    step();
    idle();
    rst_n = 1'b1;
    step();
    check("post_rd", rdata_a, 64'h0);
    check("post_busy", {32'h0, busy_a}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
